// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param
//   Multi-cycle control unit for the simple processor datapath. It decodes the
//   instruction register and sequences register-file loads, bus mux selects and
//   ALU controls. Instruction and data reads wait on a mem_ready handshake, with
//   an optional timeout that parks the FSM in a sticky bus-error state.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   run               start/continue execution (sampled on instruction boundaries)
//   IR_out            current instruction word
//   flag_out          ALU flags {cout, n, z}
//   mem_ready         memory read data valid / access accepted
//   IR_in .. DOUT_in  datapath register loads
//   R_in              one-hot register-file loads (R[NREG-1] is the PC)
//   pc_incr, W_wr     PC increment, memory write strobe
//   sel               bus mux: Ri, NREG=immediate, NREG+1=G, NREG+2=DIN
//   op, add_sub_ctrl  ALU function select
//   done              last cycle of an instruction
//   bus_err           sticky memory timeout
//   instr_count       retired-instruction counter (wraps)
module ctrl_fsm_param #(
    parameter int IW          = 16,
    parameter int RAW         = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [IW-1:0]       IR_out,
    input  logic [2:0]          flag_out,
    input  logic                mem_ready,
    output logic                IR_in,
    output logic                A_in,
    output logic                G_in,
    output logic                flag_in,
    output logic                ADDR_in,
    output logic                DOUT_in,
    output logic [(2**RAW)-1:0] R_in,
    output logic                pc_incr,
    output logic                W_wr,
    output logic [RAW:0]        sel,
    output logic [1:0]          op,
    output logic                add_sub_ctrl,
    output logic                done,
    output logic                bus_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int NREG = 2 ** RAW;
    localparam int SW   = RAW + 1;
    localparam int TW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [SW-1:0] SEL_PC  = SW'(NREG - 1);
    localparam logic [SW-1:0] SEL_IR  = SW'(NREG);
    localparam logic [SW-1:0] SEL_G   = SW'(NREG + 1);
    localparam logic [SW-1:0] SEL_DIN = SW'(NREG + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_IWAIT, S_DECODE, S_EX1, S_DWAIT, S_EX2, S_EX3, S_HALT
    } state_e;

    // Opcode 001 is MVT when imm=1 and a conditional branch when imm=0.
    typedef enum logic [2:0] {
        OP_MV = 3'b000, OP_MVT = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
        OP_LD = 3'b100, OP_ST  = 3'b101, OP_AND = 3'b110, OP_CMP = 3'b111
    } opcode_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timeoutCnt_q, timeoutCnt_d;
    logic [CNT_W-1:0]  instrCount_q;

    opcode_e           inst;
    logic              imm;
    logic [RAW-1:0]    rx, ry;
    logic [NREG-1:0]   rxOneHot;
    logic [SW-1:0]     selRx, selRy;
    logic              branchTaken;
    logic              waitExpire;
    logic              unusedIr;

    assign inst     = opcode_e'(IR_out[IW-1 -: 3]);
    assign imm      = IR_out[IW-4];
    assign rx       = IR_out[IW-5 -: RAW];
    assign ry       = IR_out[RAW-1:0];
    assign rxOneHot = NREG'(1) << rx;
    assign selRx    = {1'b0, rx};
    assign selRy    = {1'b0, ry};

    // Immediate bits between RX and RY are consumed by the datapath, not here.
    assign unusedIr = ^IR_out;

    // Branch condition chosen by the RX field; flag_out is {cout, n, z}.
    always_comb begin
        branchTaken = 1'b0;
        case (int'(rx))
            0:       branchTaken = 1'b1;
            1:       branchTaken = flag_out[0];
            2:       branchTaken = !flag_out[0];
            3:       branchTaken = !flag_out[2];
            4:       branchTaken = flag_out[2];
            5:       branchTaken = !flag_out[1];
            6:       branchTaken = flag_out[1];
            default: branchTaken = 1'b0;
        endcase
    end

    // A ready response in the expiring cycle still wins over the timeout.
    assign waitExpire = (MEM_TIMEOUT != 0) && !mem_ready && (timeoutCnt_q == TO_LAST);

    // Next state and all datapath controls. Everything defaults to inactive so
    // each state only names the controls it actually drives; HALT drives none.
    always_comb begin
        state_d      = state_q;
        IR_in        = 1'b0;
        A_in         = 1'b0;
        G_in         = 1'b0;
        flag_in      = 1'b0;
        ADDR_in      = 1'b0;
        DOUT_in      = 1'b0;
        R_in         = '0;
        pc_incr      = 1'b0;
        W_wr         = 1'b0;
        sel          = '0;
        op           = 2'b00;
        add_sub_ctrl = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                sel     = SEL_PC;
                ADDR_in = 1'b1;
                pc_incr = 1'b1;
                state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (mem_ready)       state_d = S_DECODE;
                else if (waitExpire) state_d = S_HALT;
            end
            S_DECODE: begin
                IR_in   = 1'b1;
                state_d = S_EX1;
            end
            S_EX1: begin
                case (inst)
                    OP_MV: begin
                        sel  = imm ? SEL_IR : selRy;
                        R_in = rxOneHot;
                        done = 1'b1;
                    end
                    OP_MVT: begin
                        if (imm) begin
                            sel  = SEL_IR;
                            R_in = rxOneHot;
                            done = 1'b1;
                        end else begin
                            // Branch: latch PC into A; a not-taken branch ends here.
                            sel  = SEL_PC;
                            A_in = 1'b1;
                            if (branchTaken) state_d = S_EX2;
                            else             done    = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                        sel     = selRx;
                        A_in    = 1'b1;
                        state_d = S_EX2;
                    end
                    OP_LD: begin
                        sel     = selRy;
                        ADDR_in = 1'b1;
                        state_d = S_DWAIT;
                    end
                    OP_ST: begin
                        sel     = selRy;
                        ADDR_in = 1'b1;
                        state_d = S_EX2;
                    end
                endcase
            end
            S_DWAIT: begin
                if (mem_ready)       state_d = S_EX3;
                else if (waitExpire) state_d = S_HALT;
            end
            S_EX2: begin
                case (inst)
                    OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
                        sel          = imm ? SEL_IR : selRy;
                        G_in         = 1'b1;
                        flag_in      = 1'b1;
                        add_sub_ctrl = (inst == OP_SUB) || (inst == OP_CMP);
                        op           = (inst == OP_AND) ? 2'b01 : 2'b00;
                        // CMP only updates flags, so there is no writeback cycle.
                        if (inst == OP_CMP) done    = 1'b1;
                        else                state_d = S_EX3;
                    end
                    OP_ST: begin
                        // Posted write: no handshake needed for stores.
                        sel     = selRx;
                        DOUT_in = 1'b1;
                        W_wr    = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVT: begin
                        sel     = SEL_IR;
                        G_in    = 1'b1;
                        state_d = S_EX3;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_EX3: begin
                case (inst)
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel  = SEL_G;
                        R_in = rxOneHot;
                        done = 1'b1;
                    end
                    OP_MVT: begin
                        sel  = SEL_G;
                        R_in = NREG'(1) << (NREG - 1);
                        done = 1'b1;
                    end
                    OP_LD: begin
                        sel  = SEL_DIN;
                        R_in = rxOneHot;
                        done = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Run/stop is only honoured between instructions.
        if (done) state_d = run ? S_FETCH : S_IDLE;
    end

    // Timeout counter restarts on every entry to a wait state because it is
    // held at zero whenever the FSM is anywhere else.
    always_comb begin
        timeoutCnt_d = '0;
        if ((state_q == S_IWAIT || state_q == S_DWAIT) && !mem_ready && !waitExpire)
            timeoutCnt_d = timeoutCnt_q + TW'(1);
    end

    // State, timeout and retired-instruction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timeoutCnt_q <= '0;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            if (done) instrCount_q <= instrCount_q + CNT_W'(1);
        end
    end

    assign instr_count = instrCount_q;
    assign bus_err     = (state_q == S_HALT);

endmodule
